// File: rtl/mot_ser_rx.sv
// Two-lane synchronous serial frame receiver with OPB-style read-back of data and status.
// Optional even-parity bit per lane is enabled with `define MOT_SER_PARITY_EN.
module mot_ser_rx #(
    parameter int FRAME_BITS = 16
) (
    input  logic                  OPB_CLK,
    input  logic                  OPB_RST,
    input  logic                  SER_CLK,
    input  logic                  SER_SYNC,
    input  logic                  SER_DATA0,
    input  logic                  SER_DATA1,
    input  logic                  SERIO_RST_N,
    input  logic                  RX_RE,
    input  logic                  STAT_RE,
    output logic [31:0]           RX_DO,
    output logic                  FRAME_VALID,
    output logic [FRAME_BITS-1:0] RX_WORD0,
    output logic [FRAME_BITS-1:0] RX_WORD1
);

`ifdef MOT_SER_PARITY_EN
    localparam int NBITS = FRAME_BITS + 1;
`else
    localparam int NBITS = FRAME_BITS;
`endif
    // Counter saturates one or more above NBITS so long frames never alias to a good length.
    localparam int CW = $clog2(NBITS + 2);
    localparam logic [CW-1:0] NB_C    = CW'(NBITS);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic [2:0]       clk_sq, sync_sq;
    logic [1:0]       d0_sq, d1_sq, lrst_sq;
    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [NBITS-1:0] sh0_q, sh1_q;
    logic [7:0]       frame_cnt_q;
    logic             new_data_q, overrun_q, frame_err_q, parity_err_q;
    logic             new_data_d, overrun_d, frame_err_d, parity_err_d;
    logic             clk_rise, sync_rise, sync_fall, link_rst;
    logic             in_done, len_bad, par_bad, good, stat_rd;

    assign clk_rise  = clk_sq[1] & ~clk_sq[2];
    assign sync_rise = sync_sq[1] & ~sync_sq[2];
    assign sync_fall = ~sync_sq[1] & sync_sq[2];
    assign link_rst  = ~lrst_sq[1];

    always_comb begin
        in_done = (state_q == DONE) & ~link_rst;
        len_bad = in_done & (cnt_q != NB_C);
`ifdef MOT_SER_PARITY_EN
        par_bad = in_done & (cnt_q == NB_C) & ((^sh0_q) | (^sh1_q));
`else
        par_bad = 1'b0;
`endif
        good    = in_done & ~len_bad & ~par_bad;
        stat_rd = STAT_RE & ~RX_RE;
        // Setting events take precedence over a clear on the same edge.
        frame_err_d  = (frame_err_q  & ~stat_rd) | len_bad;
        parity_err_d = (parity_err_q & ~stat_rd) | par_bad;
        overrun_d    = (overrun_q    & ~stat_rd) | (good & new_data_q);
        new_data_d   = (new_data_q   & ~RX_RE)   | good;
    end

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            clk_sq       <= '0;
            sync_sq      <= '0;
            d0_sq        <= '0;
            d1_sq        <= '0;
            lrst_sq      <= '0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            sh0_q        <= '0;
            sh1_q        <= '0;
            frame_cnt_q  <= '0;
            new_data_q   <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            FRAME_VALID  <= 1'b0;
            RX_WORD0     <= '0;
            RX_WORD1     <= '0;
            RX_DO        <= '0;
        end else begin
            clk_sq       <= {clk_sq[1:0], SER_CLK};
            sync_sq      <= {sync_sq[1:0], SER_SYNC};
            d0_sq        <= {d0_sq[0], SER_DATA0};
            d1_sq        <= {d1_sq[0], SER_DATA1};
            lrst_sq      <= {lrst_sq[0], SERIO_RST_N};
            new_data_q   <= new_data_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            FRAME_VALID  <= good;

            if (good) begin
                RX_WORD0    <= sh0_q[NBITS-1 -: FRAME_BITS];
                RX_WORD1    <= sh1_q[NBITS-1 -: FRAME_BITS];
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end

            if (RX_RE)
                RX_DO <= {16'(RX_WORD1), 16'(RX_WORD0)};
            else if (STAT_RE)
                RX_DO <= {16'b0, frame_cnt_q, 4'b0, parity_err_q, new_data_q, overrun_q, frame_err_q};

            if (link_rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                sh0_q   <= '0;
                sh1_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: if (sync_rise) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        sh0_q   <= '0;
                        sh1_q   <= '0;
                    end
                    SHIFT: begin
                        if (clk_rise) begin
                            sh0_q <= {sh0_q[NBITS-2:0], d0_sq[1]};
                            sh1_q <= {sh1_q[NBITS-2:0], d1_sq[1]};
                            if (cnt_q != CNT_MAX)
                                cnt_q <= cnt_q + 1'b1;
                        end
                        if (sync_fall)
                            state_q <= DONE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mot_ser_rx.sv
// Randomized bench for mot_ser_rx: a frame-level reference model predicts words, flags and counters.
module tb_mot_ser_rx;

`ifdef MOT_SER_PARITY_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif

    logic        OPB_CLK = 0, OPB_RST = 1;
    logic        SER_CLK = 0, SER_SYNC = 0, SER_DATA0 = 0, SER_DATA1 = 0, SERIO_RST_N = 1;
    logic        RX_RE = 0, STAT_RE = 0;
    logic [31:0] RX_DO;
    logic        FRAME_VALID;
    logic [15:0] RX_WORD0, RX_WORD1;

    int total = 0, bad = 0, fv_count = 0;

    // reference model state
    logic [15:0] m_w0 = 0, m_w1 = 0;
    logic [7:0]  m_cnt = 0;
    logic        m_new = 0, m_ovr = 0, m_ferr = 0, m_perr = 0;

    mot_ser_rx #(.FRAME_BITS(16)) dut (
        .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST), .SER_CLK(SER_CLK), .SER_SYNC(SER_SYNC),
        .SER_DATA0(SER_DATA0), .SER_DATA1(SER_DATA1), .SERIO_RST_N(SERIO_RST_N),
        .RX_RE(RX_RE), .STAT_RE(STAT_RE), .RX_DO(RX_DO), .FRAME_VALID(FRAME_VALID),
        .RX_WORD0(RX_WORD0), .RX_WORD1(RX_WORD1)
    );

    always #5 OPB_CLK = ~OPB_CLK;

    always @(posedge OPB_CLK) if (FRAME_VALID === 1'b1) fv_count <= fv_count + 1;

    function automatic logic [31:0] exp_stat();
        return {16'b0, m_cnt, 4'b0, m_perr, m_new, m_ovr, m_ferr};
    endfunction

    task automatic model_frame(input int nclk, input logic [15:0] a, b, input logic par_ok);
        if (nclk != NB) m_ferr = 1;
        else if (!par_ok) m_perr = 1;
        else begin
            if (m_new) m_ovr = 1;
            m_new = 1; m_w0 = a; m_w1 = b; m_cnt = m_cnt + 8'd1;
        end
    endtask

    task automatic model_reset();
        m_w0 = 0; m_w1 = 0; m_cnt = 0; m_new = 0; m_ovr = 0; m_ferr = 0; m_perr = 0;
    endtask

    task automatic send_bit(input logic ba, bb);
        @(negedge OPB_CLK); SER_DATA0 = ba; SER_DATA1 = bb; SER_CLK = 0;
        repeat (3) @(negedge OPB_CLK);
        SER_CLK = 1;
        repeat (4) @(negedge OPB_CLK);
    endtask

    // Sends a frame of nclk bits; returns the FRAME_VALID latency in cycles after SYNC falls (0 = none).
    task automatic drive_frame(input logic [15:0] a, b, input int nclk, input logic pa, pb, output int lat);
        logic ba, bb;
        @(negedge OPB_CLK); SER_SYNC = 1;
        repeat (6) @(negedge OPB_CLK);
        for (int i = 0; i < nclk; i++) begin
            if (i < 16) begin ba = a[15-i]; bb = b[15-i]; end
            else if (i == 16 && NB == 17) begin ba = pa; bb = pb; end
            else begin ba = 1'($urandom); bb = 1'($urandom); end
            send_bit(ba, bb);
        end
        SER_CLK = 0;
        repeat (4) @(negedge OPB_CLK);
        SER_SYNC = 0; SER_DATA0 = 0; SER_DATA1 = 0;
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge OPB_CLK); #1;
            if (FRAME_VALID === 1'b1 && lat == 0) lat = n;
        end
    endtask

    task automatic read_rx(output logic [31:0] v);
        @(negedge OPB_CLK); RX_RE = 1;
        @(negedge OPB_CLK); RX_RE = 0; v = RX_DO;
    endtask

    task automatic read_stat(output logic [31:0] v);
        @(negedge OPB_CLK); STAT_RE = 1;
        @(negedge OPB_CLK); STAT_RE = 0; v = RX_DO;
    endtask

    task automatic check_words(input string nm);
        total++;
        if (RX_WORD0 !== m_w0 || RX_WORD1 !== m_w1) begin
            bad++;
            $display("FAIL %s words: got %h/%h want %h/%h", nm, RX_WORD1, RX_WORD0, m_w1, m_w0);
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        repeat (3) @(negedge OPB_CLK);
        total++;
        if (RX_DO !== 0 || FRAME_VALID !== 0 || RX_WORD0 !== 0 || RX_WORD1 !== 0) begin
            bad++; $display("FAIL reset_outputs: got do=%h fv=%b w=%h/%h want 0", RX_DO, FRAME_VALID, RX_WORD1, RX_WORD0);
        end
        OPB_RST = 0;
        repeat (4) @(negedge OPB_CLK);
        read_stat(v);
        total++;
        if (v !== 32'h0) begin bad++; $display("FAIL reset_stat: got %h want 0", v); end
    endtask

    task automatic test_basic();
        int lat; logic [31:0] v;
        drive_frame(16'hA5C3, 16'h1234, NB, ^16'hA5C3, ^16'h1234, lat);
        model_frame(NB, 16'hA5C3, 16'h1234, 1'b1);
        total++;
        if (lat != 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", lat); end
        check_words("basic");
        read_rx(v); m_new = 0;
        total++;
        if (v !== 32'h1234A5C3) begin bad++; $display("FAIL basic_rx_do: got %h want 1234a5c3", v); end
        read_stat(v);
        total++;
        if (v !== exp_stat() || v[15:8] !== 8'd1) begin bad++; $display("FAIL basic_stat: got %h want %h", v, exp_stat()); end
        m_ferr = 0; m_ovr = 0; m_perr = 0;
        // both strobes: data read wins; then RX_DO must hold
        @(negedge OPB_CLK); RX_RE = 1; STAT_RE = 1;
        @(negedge OPB_CLK); RX_RE = 0; STAT_RE = 0; m_new = 0;
        total++;
        if (RX_DO !== 32'h1234A5C3) begin bad++; $display("FAIL priority: got %h want 1234a5c3", RX_DO); end
        repeat (5) @(negedge OPB_CLK);
        total++;
        if (RX_DO !== 32'h1234A5C3) begin bad++; $display("FAIL hold: got %h want 1234a5c3", RX_DO); end
    endtask

    task automatic test_short();
        int lat, fv0; logic [31:0] v;
        fv0 = fv_count;
        drive_frame(16'h5555, 16'hAAAA, NB - 1, 1'b0, 1'b0, lat);
        model_frame(NB - 1, 16'h5555, 16'hAAAA, 1'b1);
        total++;
        if (lat != 0 || fv_count != fv0) begin bad++; $display("FAIL short_no_valid: got lat=%0d pulses=%0d want 0", lat, fv_count - fv0); end
        check_words("short");
        read_stat(v);
        total++;
        if (v !== exp_stat() || v[0] !== 1'b1) begin bad++; $display("FAIL short_stat1: got %h want %h", v, exp_stat()); end
        m_ferr = 0; m_ovr = 0; m_perr = 0;
        read_stat(v);
        total++;
        if (v[0] !== 1'b0 || v !== exp_stat()) begin bad++; $display("FAIL short_stat2: got %h want %h", v, exp_stat()); end
    endtask

    task automatic test_overrun();
        int lat; logic [31:0] v; logic [15:0] a, b;
        for (int k = 0; k < 2; k++) begin
            a = 16'($urandom); b = 16'($urandom);
            drive_frame(a, b, NB, ^a, ^b, lat);
            model_frame(NB, a, b, 1'b1);
            total++;
            if (lat != 4) begin bad++; $display("FAIL overrun_latency%0d: got %0d want 4", k, lat); end
        end
        check_words("overrun");
        read_stat(v);
        total++;
        if (v !== exp_stat() || v[1] !== 1'b1) begin bad++; $display("FAIL overrun_stat: got %h want %h", v, exp_stat()); end
        m_ferr = 0; m_ovr = 0; m_perr = 0;
        read_rx(v); m_new = 0;
        total++;
        if (v !== {m_w1, m_w0}) begin bad++; $display("FAIL overrun_rx: got %h want %h", v, {m_w1, m_w0}); end
    endtask

    task automatic test_serio_rst();
        int lat, fv0; logic [31:0] v;
        fv0 = fv_count;
        @(negedge OPB_CLK); SER_SYNC = 1;
        repeat (6) @(negedge OPB_CLK);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom), 1'($urandom));
        SER_CLK = 0; SERIO_RST_N = 0;
        repeat (5) @(negedge OPB_CLK);
        SERIO_RST_N = 1;
        repeat (3) @(negedge OPB_CLK);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom), 1'($urandom));
        SER_CLK = 0;
        repeat (4) @(negedge OPB_CLK);
        SER_SYNC = 0;
        repeat (12) @(negedge OPB_CLK);
        total++;
        if (fv_count != fv0) begin bad++; $display("FAIL serio_abort: got %0d pulses want 0", fv_count - fv0); end
        drive_frame(16'hFFFF, 16'h0000, NB, 1'b0, 1'b0, lat);
        model_frame(NB, 16'hFFFF, 16'h0000, 1'b1);
        total++;
        if (lat != 4) begin bad++; $display("FAIL serio_latency: got %0d want 4", lat); end
        check_words("serio");
        read_stat(v);
        total++;
        if (v !== exp_stat() || v[3:0] !== 4'b0100) begin bad++; $display("FAIL serio_stat: got %h want %h", v, exp_stat()); end
        m_ferr = 0; m_ovr = 0; m_perr = 0;
    endtask

    task automatic test_opb_rst();
        int lat; logic [31:0] v; logic [15:0] a, b;
        @(negedge OPB_CLK); SER_SYNC = 1;
        repeat (6) @(negedge OPB_CLK);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
        @(negedge OPB_CLK); OPB_RST = 1; #1;
        model_reset();
        total++;
        if (RX_DO !== 0 || FRAME_VALID !== 0 || RX_WORD0 !== 0 || RX_WORD1 !== 0) begin
            bad++; $display("FAIL opbrst_outputs: got do=%h fv=%b w=%h/%h want 0", RX_DO, FRAME_VALID, RX_WORD1, RX_WORD0);
        end
        SER_SYNC = 0; SER_CLK = 0;
        repeat (3) @(negedge OPB_CLK);
        OPB_RST = 0;
        repeat (4) @(negedge OPB_CLK);
        a = 16'($urandom); b = 16'($urandom);
        drive_frame(a, b, NB, ^a, ^b, lat);
        model_frame(NB, a, b, 1'b1);
        total++;
        if (lat != 4) begin bad++; $display("FAIL opbrst_latency: got %0d want 4", lat); end
        read_rx(v); m_new = 0;
        total++;
        if (v !== {b, a}) begin bad++; $display("FAIL opbrst_rx: got %h want %h", v, {b, a}); end
        read_stat(v);
        total++;
        if (v !== exp_stat()) begin bad++; $display("FAIL opbrst_stat: got %h want %h", v, exp_stat()); end
        m_ferr = 0; m_ovr = 0; m_perr = 0;
    endtask

    task automatic test_random();
        int lat, nclk; logic [31:0] v; logic [15:0] a, b;
        for (int k = 0; k < 8; k++) begin
            a = 16'($urandom); b = 16'($urandom);
            nclk = NB - 1 + int'($urandom_range(0, 2));
            drive_frame(a, b, nclk, ^a, ^b, lat);
            model_frame(nclk, a, b, 1'b1);
            total++;
            if (lat != ((nclk == NB) ? 4 : 0)) begin
                bad++; $display("FAIL rand%0d_latency: got %0d want %0d (nclk=%0d)", k, lat, (nclk == NB) ? 4 : 0, nclk);
            end
            check_words("rand");
            if ($urandom_range(0, 1) == 1) begin
                read_rx(v); m_new = 0;
                total++;
                if (v !== {m_w1, m_w0}) begin bad++; $display("FAIL rand%0d_rx: got %h want %h", k, v, {m_w1, m_w0}); end
            end
            if ($urandom_range(0, 1) == 1) begin
                read_stat(v);
                total++;
                if (v !== exp_stat()) begin bad++; $display("FAIL rand%0d_stat: got %h want %h", k, v, exp_stat()); end
                m_ferr = 0; m_ovr = 0; m_perr = 0;
            end
        end
        read_stat(v);
        total++;
        if (v !== exp_stat()) begin bad++; $display("FAIL rand_final_stat: got %h want %h", v, exp_stat()); end
        m_ferr = 0; m_ovr = 0; m_perr = 0;
    endtask

`ifdef MOT_SER_PARITY_EN
    task automatic test_parity();
        int lat; logic [31:0] v;
        drive_frame(16'h0001, 16'h0000, NB, 1'b0, 1'b0, lat);
        model_frame(NB, 16'h0001, 16'h0000, 1'b0);
        total++;
        if (lat != 0) begin bad++; $display("FAIL parity_bad_valid: got lat=%0d want 0", lat); end
        read_stat(v);
        total++;
        if (v !== exp_stat() || v[3] !== 1'b1) begin bad++; $display("FAIL parity_bad_stat: got %h want %h", v, exp_stat()); end
        m_ferr = 0; m_ovr = 0; m_perr = 0;
        drive_frame(16'h0001, 16'h0000, NB, 1'b1, 1'b0, lat);
        model_frame(NB, 16'h0001, 16'h0000, 1'b1);
        total++;
        if (lat != 4) begin bad++; $display("FAIL parity_good_latency: got %0d want 4", lat); end
        check_words("parity");
        read_stat(v);
        total++;
        if (v !== exp_stat()) begin bad++; $display("FAIL parity_good_stat: got %h want %h", v, exp_stat()); end
        m_ferr = 0; m_ovr = 0; m_perr = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_overrun();
        test_serio_rst();
        test_opb_rst();
        test_random();
`ifdef MOT_SER_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
